ula_arbiter_ctrl: RTL
=====================

ULA_ARBITER_CTRL -- requirements
Module: ula_arbiter_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the completed-operation counter.
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  input  2  per-requester command valid (bit i = requester i).
REQ-005 Port: req_ready  output  2  per-requester command accept strobe.
REQ-006 Port: req0_a / req1_a  input  8  operand A per requester.
REQ-007 Port: req0_b / req1_b  input  8  operand B per requester.
REQ-008 Port: req0_s / req1_s  input  4  ALU function select per requester.
REQ-009 Port: req0_m / req1_m  input  1  ALU mode (0 arithmetic, 1 logic) per requester.
REQ-010 Port: req0_cin / req1_cin  input  1  ALU carry-in per requester.
REQ-011 Port: rsp_valid  output  1  result available.
REQ-012 Port: rsp_ready  input  1  consumer accepts result.
REQ-013 Port: rsp_id  output  1  requester that issued the result.
REQ-014 Port: rsp_f  output  8  ALU result.
REQ-015 Port: rsp_cout / rsp_ovf / rsp_eq  output  1 each  carry-out, signed overflow, A=B flag.
REQ-016 Port: busy  output  1  high in any state other than IDLE.
REQ-017 Port: op_count  output  CNT_W  number of completed response handshakes.

Function
REQ-018 FSM states SHALL be IDLE, EXEC, RESP.
REQ-019 IDLE: with any req_valid high, grant one requester, assert its req_ready for exactly that cycle, latch its a/b/s/m/cin, record rsp_id, go to EXEC.
REQ-020 Both valid in IDLE: grant the requester not served by the last completed grant (round-robin); rr pointer starts at requester 0.
REQ-021 One valid in IDLE: grant it regardless of the rr pointer.
REQ-022 req_ready SHALL be 0 in EXEC and RESP; req_ready is never high for both bits.
REQ-023 EXEC (one cycle): shared ALU driven from latched operands only; f, c_out, overflow, a_eq_b registered into rsp_* at the end of EXEC; go to RESP.
REQ-024 RESP: rsp_valid=1; rsp_* stable until rsp_valid && rsp_ready; then rsp_valid=0, op_count+1, rr pointer updated, go to IDLE.
REQ-025 Latency: command accepted at cycle N -> rsp_valid high at cycle N+2; with rsp_ready held high, back-to-back throughput is one op per 3 cycles.
REQ-026 rsp_ready low SHALL hold RESP indefinitely with no new command accepted.
REQ-027 Requester input changes after acceptance SHALL NOT affect the in-flight result.
REQ-028 op_count SHALL wrap from 2^CNT_W-1 to 0 without flag.
REQ-029 rsp_* outputs SHALL be don't-care-free: hold last result while rsp_valid=0.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_f=0, rsp_cout=rsp_ovf=rsp_eq=0, busy=0, op_count=0, rr pointer to requester 0.
REQ-031 Reset in EXEC or RESP SHALL discard the in-flight operation; no response produced after release.

Structure
REQ-032 Shared package ula_pkg SHALL hold the FSM state enum, requester-id type, and function constants ULA_S_ADD=4'b0101, ULA_S_SUB=4'b1000.
REQ-033 Exactly one ula_8_bits instance SHALL be the shared datapath; no other arithmetic in this block except op_count.

Verification
REQ-034 Single req0: a=01,b=02,s=0101,m=0,cin=0 -> rsp_valid at N+2, rsp_f=03, cout=0, ovf=0, eq=0, rsp_id=0, op_count=1.
REQ-035 Overflow: req1 a=7F,b=01,s=0101 -> rsp_f=80, ovf=1, cout=0, rsp_id=1; then a=FF,b=01 -> rsp_f=00, cout=1.
REQ-036 Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; one accept every 3 cycles.
REQ-037 Backpressure: rsp_ready=0 for 10 cycles in RESP (sub s=1000, a=0A,b=05) -> rsp_f=05 held stable, req_ready stays 0, then single handshake.
REQ-038 rst_n pulsed low during EXEC -> all outputs zero immediately, no rsp_valid after release, op_count=0.
REQ-039 CNT_W=2: 5 completed ops -> op_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg: shared types and constants for the ULA arbiter controller and its ALU.
// Holds the FSM state encoding, the requester-id type and the ALU function codes.
package ula_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef logic req_id_t;
    localparam logic [3:0] ULA_S_ADD = 4'b0101;
    localparam logic [3:0] ULA_S_SUB = 4'b1000;
endpackage

// File: rtl/ula_arbiter_ctrl_if.sv
// ula_arbiter_ctrl_if: request/response bus between two requesters, one result consumer
// and the arbiter controller.
//   req_valid/req_ready : per-requester command handshake (bit i = requester i)
//   reqN_a/b/s/m/cin    : operands, function select, mode and carry-in of requester N
//   rsp_valid/rsp_ready : result handshake
//   rsp_id/f/cout/ovf/eq: issuing requester, result byte and flags
// master = requesters plus consumer side, slave = arbiter controller side.
interface ula_arbiter_ctrl_if;
    import ula_pkg::*;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req0_a, req1_a, req0_b, req1_b;
    logic [3:0] req0_s, req1_s;
    logic       req0_m, req1_m, req0_cin, req1_cin;
    logic       rsp_valid, rsp_ready;
    req_id_t    rsp_id;
    logic [7:0] rsp_f;
    logic       rsp_cout, rsp_ovf, rsp_eq;
    modport master (
        output req_valid, req0_a, req1_a, req0_b, req1_b, req0_s, req1_s,
               req0_m, req1_m, req0_cin, req1_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_f, rsp_cout, rsp_ovf, rsp_eq
    );
    modport slave (
        input  req_valid, req0_a, req1_a, req0_b, req1_b, req0_s, req1_s,
               req0_m, req1_m, req0_cin, req1_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_f, rsp_cout, rsp_ovf, rsp_eq
    );
endinterface

// File: rtl/ula_8_bits.sv
// ula_8_bits: combinational 8-bit ALU used as the shared datapath.
//   a_i, b_i : operands          s_i : function select   m_i : 0 arithmetic, 1 logic
//   cin_i    : carry-in (borrow-in for SUB)
//   f_o      : result   cout_o : carry-out   ovf_o : signed overflow   eq_o : a_i == b_i
// Arithmetic: ADD f=a+b+cin, SUB f=a-b-cin (cout=1 means no borrow), others f=a+cin.
// Logic (selected by s_i[1:0]): ~a, a&b, a|b, a^b; cout and ovf are 0.
module ula_8_bits
    import ula_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [3:0] s_i,
    input  logic       m_i,
    input  logic       cin_i,
    output logic [7:0] f_o,
    output logic       cout_o,
    output logic       ovf_o,
    output logic       eq_o
);
    logic [7:0] bop;
    logic       ci;
    logic [8:0] sum;
    logic [7:0] lf;
    always_comb begin
        // Subtraction is a + ~b + ~borrow, so one adder covers every arithmetic code.
        bop = (s_i == ULA_S_SUB) ? ~b_i : (s_i == ULA_S_ADD) ? b_i : 8'h00;
        ci  = (s_i == ULA_S_SUB) ? ~cin_i : cin_i;
        sum = {1'b0, a_i} + {1'b0, bop} + {8'h00, ci};
        lf  = (s_i[1:0] == 2'd0) ? ~a_i :
              (s_i[1:0] == 2'd1) ? (a_i & b_i) :
              (s_i[1:0] == 2'd2) ? (a_i | b_i) : (a_i ^ b_i);
        f_o    = m_i ? lf : sum[7:0];
        cout_o = ~m_i & sum[8];
        ovf_o  = ~m_i & (a_i[7] == bop[7]) & (sum[7] != a_i[7]);
        eq_o   = (a_i == b_i);
    end
endmodule

// File: rtl/ula_arbiter_ctrl.sv
// ula_arbiter_ctrl: round-robin arbiter sharing one ula_8_bits between two requesters.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : request/response bus (slave side)
//   busy       : high whenever the FSM is not IDLE
//   op_count   : completed response handshakes, wraps silently
// Flow: IDLE grants and latches a command, EXEC registers the ALU result, RESP holds it
// until the consumer takes it.
module ula_arbiter_ctrl
    import ula_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ula_arbiter_ctrl_if.slave bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    state_t           state_q;
    req_id_t          rr_q, id_q, gnt_id, rsp_id_q;
    logic [7:0]       a_q, b_q, a_d, b_d, rsp_f_q, alu_f;
    logic [3:0]       s_q, s_d;
    logic             m_q, cin_q, m_d, cin_d;
    logic             rsp_valid_q, rsp_cout_q, rsp_ovf_q, rsp_eq_q;
    logic             alu_cout, alu_ovf, alu_eq;
    logic [CNT_W-1:0] cnt_q;
    always_comb begin
        // rr_q only decides when both are valid; a lone requester always wins.
        gnt_id = bus.req_valid[1] & (~bus.req_valid[0] | rr_q);
        a_d    = gnt_id ? bus.req1_a   : bus.req0_a;
        b_d    = gnt_id ? bus.req1_b   : bus.req0_b;
        s_d    = gnt_id ? bus.req1_s   : bus.req0_s;
        m_d    = gnt_id ? bus.req1_m   : bus.req0_m;
        cin_d  = gnt_id ? bus.req1_cin : bus.req0_cin;
    end
    // Ready is combinational so acceptance happens in the IDLE cycle itself; gated by
    // rst_n so it is forced low while reset is asserted.
    assign bus.req_ready = (rst_n && state_q == IDLE && |bus.req_valid) ?
                           (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_f     = rsp_f_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.rsp_ovf   = rsp_ovf_q;
    assign bus.rsp_eq    = rsp_eq_q;
    assign busy          = (state_q != IDLE);
    assign op_count      = cnt_q;
    ula_8_bits u_alu (
        .a_i    (a_q),
        .b_i    (b_q),
        .s_i    (s_q),
        .m_i    (m_q),
        .cin_i  (cin_q),
        .f_o    (alu_f),
        .cout_o (alu_cout),
        .ovf_o  (alu_ovf),
        .eq_o   (alu_eq)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            id_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            m_q         <= 1'b0;
            cin_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_f_q     <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            rsp_eq_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (|bus.req_valid) begin
                    id_q    <= gnt_id;
                    a_q     <= a_d;
                    b_q     <= b_d;
                    s_q     <= s_d;
                    m_q     <= m_d;
                    cin_q   <= cin_d;
                    state_q <= EXEC;
                end
                EXEC: begin
                    rsp_f_q     <= alu_f;
                    rsp_cout_q  <= alu_cout;
                    rsp_ovf_q   <= alu_ovf;
                    rsp_eq_q    <= alu_eq;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    cnt_q       <= cnt_q + CNT_W'(1);
                    rr_q        <= ~rsp_id_q;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
